// File: rtl/sram_phy_pkg.sv
// Shared types and constants for the asynchronous SRAM physical-side controller.
package sram_phy_pkg;

   localparam int SRAM_ADDR_WIDTH = 20;
   localparam int SRAM_DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WR_SETUP,
      WR_PULSE,
      WR_HOLD
   } SRAM_PHY_STATE;

   typedef struct packed {
      logic                           we;
      logic [SRAM_ADDR_WIDTH-1:0]     addr;
      logic [SRAM_DATA_WIDTH-1:0]     wdata;
      logic [SRAM_DATA_WIDTH/8-1:0]   be;
   } SRAM_PHY_REQ;

   function automatic int maxInt(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sram_phy.sv
// Sequences CE#/OE#/WE#/BE# and the data-bus drive for single-word SRAM accesses,
// returning a one-cycle response on completion. Every SRAM-side output is a register.
module sram_phy
   import sram_phy_pkg::*;
#(
   parameter int ADDR_WIDTH  = SRAM_ADDR_WIDTH,
   parameter int DATA_WIDTH  = SRAM_DATA_WIDTH,
   parameter int READ_CYCLES = 3,
   parameter int WE_CYCLES   = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_be,
   output logic                    resp_valid,
   output logic [DATA_WIDTH-1:0]   resp_rdata,
   output logic [ADDR_WIDTH-1:0]   sram_addr,
   output logic [DATA_WIDTH-1:0]   sram_dq_o,
   output logic                    sram_dq_oe,
   input  logic [DATA_WIDTH-1:0]   sram_dq_i,
   output logic                    sram_ce_n,
   output logic                    sram_oe_n,
   output logic                    sram_we_n,
   output logic [DATA_WIDTH/8-1:0] sram_be_n
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam int CNT_W    = $clog2(maxInt(READ_CYCLES, WE_CYCLES) + 1);
   localparam logic [CNT_W-1:0] READ_LOAD = CNT_W'(READ_CYCLES - 1);
   localparam logic [CNT_W-1:0] WE_LOAD   = CNT_W'(WE_CYCLES - 1);

   SRAM_PHY_STATE state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] dqOut_q, dqOut_d;
   logic                  dqOe_q, dqOe_d;
   logic                  ceN_q, ceN_d;
   logic                  oeN_q, oeN_d;
   logic                  weN_q, weN_d;
   logic [BE_WIDTH-1:0]   beN_q, beN_d;
   logic                  respValid_q, respValid_d;
   logic [DATA_WIDTH-1:0] respRdata_q, respRdata_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         dqOut_q     <= '0;
         dqOe_q      <= 1'b0;
         ceN_q       <= 1'b1;
         oeN_q       <= 1'b1;
         weN_q       <= 1'b1;
         beN_q       <= '1;
         respValid_q <= 1'b0;
         respRdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         dqOut_q     <= dqOut_d;
         dqOe_q      <= dqOe_d;
         ceN_q       <= ceN_d;
         oeN_q       <= oeN_d;
         weN_q       <= weN_d;
         beN_q       <= beN_d;
         respValid_q <= respValid_d;
         respRdata_q <= respRdata_d;
      end
   end

   // Outputs are computed one state ahead so that the registered strobes line up
   // with the state they belong to; address and write data simply hold in IDLE.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      dqOut_d     = dqOut_q;
      dqOe_d      = dqOe_q;
      ceN_d       = ceN_q;
      oeN_d       = oeN_q;
      weN_d       = weN_q;
      beN_d       = beN_q;
      respValid_d = 1'b0;
      respRdata_d = respRdata_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               addr_d = req_addr;
               ceN_d  = 1'b0;
               if (req_we) begin
                  state_d = WR_SETUP;
                  dqOut_d = req_wdata;
                  dqOe_d  = 1'b1;
                  beN_d   = ~req_be;
               end else begin
                  state_d = READ;
                  cnt_d   = READ_LOAD;
                  oeN_d   = 1'b0;
                  beN_d   = '0;
               end
            end
         end
         READ: begin
            if (cnt_q == '0) begin
               state_d     = IDLE;
               respRdata_d = sram_dq_i;
               respValid_d = 1'b1;
               ceN_d       = 1'b1;
               oeN_d       = 1'b1;
               beN_d       = '1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WR_SETUP: begin
            state_d = WR_PULSE;
            cnt_d   = WE_LOAD;
            weN_d   = 1'b0;
         end
         WR_PULSE: begin
            if (cnt_q == '0) begin
               state_d = WR_HOLD;
               weN_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WR_HOLD: begin
            state_d     = IDLE;
            respValid_d = 1'b1;
            ceN_d       = 1'b1;
            dqOe_d      = 1'b0;
            beN_d       = '1;
         end
         default: state_d = IDLE;
      endcase
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = respValid_q;
   assign resp_rdata = respRdata_q;
   assign sram_addr  = addr_q;
   assign sram_dq_o  = dqOut_q;
   assign sram_dq_oe = dqOe_q;
   assign sram_ce_n  = ceN_q;
   assign sram_oe_n  = oeN_q;
   assign sram_we_n  = weN_q;
   assign sram_be_n  = beN_q;

endmodule

// File: tb/tb_sram_phy.sv
// Directed bench for sram_phy: table of read/write transactions checked cycle by cycle,
// plus hand-written reset and mid-write reset sequences.
module tb_sram_phy;

   localparam int ADDR_WIDTH  = 20;
   localparam int DATA_WIDTH  = 32;
   localparam int READ_CYCLES = 3;
   localparam int WE_CYCLES   = 2;

   typedef struct {
      logic        we;
      logic [19:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] dqIn;
      logic [3:0]  expBeN;
      logic [31:0] expRdata;
      logic        noise;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [19:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [19:0] sram_addr;
   logic [31:0] sram_dq_o;
   logic        sram_dq_oe;
   logic [31:0] sram_dq_i;
   logic        sram_ce_n;
   logic        sram_oe_n;
   logic        sram_we_n;
   logic [3:0]  sram_be_n;

   int          checks;
   int          failures;
   logic [31:0] prevRdata;
   vec_t        vecs[6];
   vec_t        tailRead;

   sram_phy #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .READ_CYCLES(READ_CYCLES),
      .WE_CYCLES  (WE_CYCLES)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .resp_valid(resp_valid),
      .resp_rdata(resp_rdata),
      .sram_addr (sram_addr),
      .sram_dq_o (sram_dq_o),
      .sram_dq_oe(sram_dq_oe),
      .sram_dq_i (sram_dq_i),
      .sram_ce_n (sram_ce_n),
      .sram_oe_n (sram_oe_n),
      .sram_we_n (sram_we_n),
      .sram_be_n (sram_be_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Issues one request at a negedge in IDLE, then checks every cycle up to and
   // including the response cycle; returns at the negedge of the response cycle.
   task automatic applyStimulus(input string tag, input vec_t v);
      int   respCycle;
      logic busy;
      respCycle = v.we ? (WE_CYCLES + 3) : (READ_CYCLES + 1);
      sram_dq_i = v.dqIn;
      req_we    = v.we;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      req_be    = v.be;
      req_valid = 1'b1;
      checkOutput({tag, ".ready_at_accept"}, 64'(req_ready), 64'(1'b1));
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int c = 1; c <= respCycle; c++) begin
         busy = (c < respCycle);
         checkOutput($sformatf("%s.c%0d.ce_n", tag, c), 64'(sram_ce_n), 64'(!busy));
         checkOutput($sformatf("%s.c%0d.ready", tag, c), 64'(req_ready), 64'(!busy));
         checkOutput($sformatf("%s.c%0d.resp_valid", tag, c), 64'(resp_valid), 64'(!busy));
         checkOutput($sformatf("%s.c%0d.addr", tag, c), 64'(sram_addr), 64'(v.addr));
         checkOutput($sformatf("%s.c%0d.be_n", tag, c), 64'(sram_be_n), busy ? 64'(v.expBeN) : 64'(4'hF));
         checkOutput($sformatf("%s.c%0d.oe_overlap", tag, c), 64'(sram_dq_oe & ~sram_oe_n), 64'(1'b0));
         if (v.we) begin
            checkOutput($sformatf("%s.c%0d.oe_n", tag, c), 64'(sram_oe_n), 64'(1'b1));
            checkOutput($sformatf("%s.c%0d.we_n", tag, c), 64'(sram_we_n),
                        64'(!(c >= 2 && c <= WE_CYCLES + 1)));
            checkOutput($sformatf("%s.c%0d.dq_oe", tag, c), 64'(sram_dq_oe), 64'(busy));
            checkOutput($sformatf("%s.c%0d.dq_o", tag, c), 64'(sram_dq_o), 64'(v.wdata));
            checkOutput($sformatf("%s.c%0d.rdata", tag, c), 64'(resp_rdata), 64'(prevRdata));
         end else begin
            checkOutput($sformatf("%s.c%0d.oe_n", tag, c), 64'(sram_oe_n), 64'(!busy));
            checkOutput($sformatf("%s.c%0d.we_n", tag, c), 64'(sram_we_n), 64'(1'b1));
            checkOutput($sformatf("%s.c%0d.dq_oe", tag, c), 64'(sram_dq_oe), 64'(1'b0));
            checkOutput($sformatf("%s.c%0d.rdata", tag, c), 64'(resp_rdata),
                        busy ? 64'(prevRdata) : 64'(v.expRdata));
         end
         if (busy && v.noise) begin
            req_valid = c[0];
            req_addr  = ~v.addr;
            req_we    = ~v.we;
         end
         if (c < respCycle) @(negedge clk);
      end
      req_valid = 1'b0;
      if (!v.we) prevRdata = v.expRdata;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      prevRdata = 32'h0;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
      sram_dq_i = '0;

      //            we    addr      wdata          be       dqIn           expBeN   expRdata       noise
      vecs[0] = '{1'b0, 20'h00012, 32'h0000_0000, 4'b0000, 32'hDEAD_BEEF, 4'b0000, 32'hDEAD_BEEF, 1'b0};
      vecs[1] = '{1'b1, 20'h00034, 32'hA5A5_0F0F, 4'b0011, 32'hBAD0_BAD0, 4'b1100, 32'hDEAD_BEEF, 1'b0};
      vecs[2] = '{1'b0, 20'hFFFFF, 32'h0000_0000, 4'b0000, 32'h1234_5678, 4'b0000, 32'h1234_5678, 1'b1};
      vecs[3] = '{1'b1, 20'h00001, 32'h0000_0000, 4'b0000, 32'h5555_AAAA, 4'b1111, 32'h1234_5678, 1'b0};
      vecs[4] = '{1'b1, 20'h00100, 32'hFFFF_FFFF, 4'b1111, 32'h0F0F_0F0F, 4'b0000, 32'h1234_5678, 1'b1};
      vecs[5] = '{1'b0, 20'h00000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b0};
      tailRead = '{1'b0, 20'h00077, 32'h0000_0000, 4'b0000, 32'hCAFE_F00D, 4'b0000, 32'hCAFE_F00D, 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst.ce_n", 64'(sram_ce_n), 64'(1'b1));
      checkOutput("rst.oe_n", 64'(sram_oe_n), 64'(1'b1));
      checkOutput("rst.we_n", 64'(sram_we_n), 64'(1'b1));
      checkOutput("rst.be_n", 64'(sram_be_n), 64'(4'hF));
      checkOutput("rst.dq_oe", 64'(sram_dq_oe), 64'(1'b0));
      checkOutput("rst.addr", 64'(sram_addr), 64'(0));
      checkOutput("rst.dq_o", 64'(sram_dq_o), 64'(0));
      checkOutput("rst.resp_valid", 64'(resp_valid), 64'(1'b0));
      checkOutput("rst.rdata", 64'(resp_rdata), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst.ready_after", 64'(req_ready), 64'(1'b1));

      // Consecutive vectors are issued in the previous response cycle (back-to-back).
      for (int i = 0; i < 6; i++) begin
         applyStimulus($sformatf("v%0d", i), vecs[i]);
      end

      // Reset asserted during the first WE# cycle of a write.
      req_we    = 1'b1;
      req_addr  = 20'h00055;
      req_wdata = 32'h1122_3344;
      req_be    = 4'b1111;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("mid.c1.ce_n", 64'(sram_ce_n), 64'(1'b0));
      checkOutput("mid.c1.dq_oe", 64'(sram_dq_oe), 64'(1'b1));
      @(negedge clk);
      checkOutput("mid.c2.we_n", 64'(sram_we_n), 64'(1'b0));
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("mid.c3.we_n", 64'(sram_we_n), 64'(1'b1));
      checkOutput("mid.c3.dq_oe", 64'(sram_dq_oe), 64'(1'b0));
      checkOutput("mid.c3.ce_n", 64'(sram_ce_n), 64'(1'b1));
      checkOutput("mid.c3.be_n", 64'(sram_be_n), 64'(4'hF));
      checkOutput("mid.c3.addr", 64'(sram_addr), 64'(0));
      checkOutput("mid.c3.rdata", 64'(resp_rdata), 64'(0));
      rst_n = 1'b1;
      prevRdata = 32'h0;
      for (int c = 0; c < 5; c++) begin
         checkOutput($sformatf("mid.post%0d.resp_valid", c), 64'(resp_valid), 64'(1'b0));
         checkOutput($sformatf("mid.post%0d.ready", c), 64'(req_ready), 64'(1'b1));
         @(negedge clk);
      end
      applyStimulus("tail", tailRead);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
